// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the X-stage branch/jump redirect controller.
// Holds the redirect FSM state type, default widths and RV32 branch funct3 codes.
package branch_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2
    } redirect_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 010 and 011 are the only funct3 codes that are not conditional branches.
    function automatic logic is_branch_funct3(input logic [2:0] funct3);
        return (funct3 == F3_BEQ)  || (funct3 == F3_BNE)  ||
               (funct3 == F3_BLT)  || (funct3 == F3_BGE)  ||
               (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns resolved X-stage branches/jumps into a fetch redirect with an F/D flush,
// holding X while fetch stalls, plus branch/taken performance counters.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             if_stall,
    input  logic             clr_counts,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_fd,
    output logic             ex_hold,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    redirect_state_e state_q;
    redirect_state_e state_d;

    logic            in_idle;
    logic            redirect_event;
    logic            accept;
    logic            br_inc;
    logic            taken_inc;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;

    assign in_idle        = (state_q == IDLE);
    assign redirect_event = ex_valid & (ex_is_jump | (ex_is_branch & ex_taken));
    assign accept         = in_idle & redirect_event;

    // A jump that also claims to be a branch is a jump and stays out of the counters.
    assign br_inc    = in_idle & ex_valid & ex_is_branch & ~ex_is_jump;
    assign taken_inc = br_inc & ex_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (redirect_event) state_d = REDIRECT;
            REDIRECT: if (!if_stall)      state_d = SHADOW;
            SHADOW:                       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = 1'b0;
        flush_fd       = 1'b0;
        ex_hold        = 1'b0;
        case (state_q)
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush_fd       = 1'b1;
                ex_hold        = if_stall;
            end
            SHADOW: begin
                flush_fd = 1'b1;
            end
            default: begin
                redirect_valid = 1'b0;
            end
        endcase
    end

    // Target is captured only on acceptance, so it stays stable while fetch stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            pc_q <= {ex_target[XLEN-1:2], 2'b00};
            if (ex_target[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign redirect_pc  = pc_q;
    assign misalign_err = misalign_q;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_br_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (br_inc),
        .clr  (clr_counts),
        .count(br_count)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_taken_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (taken_inc),
        .clr  (clr_counts),
        .count(taken_count)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a queue of per-cycle expectations.
// Counters use a 4-bit width so saturation is reachable quickly.
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             if_stall;
    logic             clr_counts;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_fd;
    logic             ex_hold;
    logic             misalign_err;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    branch_redirect_ctrl #(
        .XLEN (XLEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .if_stall      (if_stall),
        .clr_counts    (clr_counts),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_fd      (flush_fd),
        .ex_hold       (ex_hold),
        .misalign_err  (misalign_err),
        .br_count      (br_count),
        .taken_count   (taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rv;
        logic        ff;
        logic        hold;
        logic        me;
        logic [31:0] pc;
        int          br;
        int          tk;
    } exp_t;

    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, advanced by the sequence before each step.
    int          m_br  = 0;
    int          m_tk  = 0;
    logic [31:0] m_pc  = '0;
    logic        m_me  = 1'b0;

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic rv, input logic ff, input logic hold);
        exp_t e;
        e.tag  = tag;
        e.rv   = rv;
        e.ff   = ff;
        e.hold = hold;
        e.me   = m_me;
        e.pc   = m_pc;
        e.br   = m_br;
        e.tk   = m_tk;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "redirect_valid", 32'(redirect_valid), 32'(e.rv));
            cmp(e.tag, "flush_fd",       32'(flush_fd),       32'(e.ff));
            cmp(e.tag, "ex_hold",        32'(ex_hold),        32'(e.hold));
            cmp(e.tag, "redirect_pc",    redirect_pc,         e.pc);
            cmp(e.tag, "misalign_err",   32'(misalign_err),   32'(e.me));
            cmp(e.tag, "br_count",       32'(br_count),       32'(e.br));
            cmp(e.tag, "taken_count",    32'(taken_count),    32'(e.tk));
        end
    endtask

    task automatic step(input string tag, input logic v, input logic b, input logic j,
                        input logic t, input logic [31:0] tgt, input logic stall,
                        input logic clr, input logic rv, input logic ff, input logic hold);
        @(negedge clk);
        ex_valid     = v;
        ex_is_branch = b;
        ex_is_jump   = j;
        ex_taken     = t;
        ex_target    = tgt;
        if_stall     = stall;
        clr_counts   = clr;
        push(tag, rv, ff, hold);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input string tag, input logic rv, input logic ff);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rv, ff, 1'b0);
    endtask

    function automatic int sat_inc(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    initial begin
        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jump   = 1'b0;
        ex_taken     = 1'b0;
        ex_target    = '0;
        if_stall     = 1'b0;
        clr_counts   = 1'b0;

        @(posedge clk);
        #1;
        push("reset", 1'b0, 1'b0, 1'b0);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        // Taken BEQ, no stall: one REDIRECT then one SHADOW cycle.
        m_br = 1; m_tk = 1; m_pc = 32'h100;
        step("beq_taken", 1, 1, 0, 1, 32'h100, 0, 0, 1, 1, 0);
        idle("beq_shadow", 0, 1);
        idle("beq_idle",   0, 0);

        // JAL with fetch stalled for three REDIRECT cycles.
        m_pc = 32'h200;
        step("jal_stall1", 1, 0, 1, 0, 32'h200, 1, 0, 1, 1, 1);
        step("jal_stall2", 0, 0, 0, 0, 32'h0,   1, 0, 1, 1, 1);
        step("jal_stall3", 0, 0, 0, 0, 32'h0,   1, 0, 1, 1, 1);
        step("jal_accept", 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 0);
        idle("jal_idle", 0, 0);

        // Redirect events while REDIRECT/SHADOW are ignored and not counted.
        m_br = 2; m_tk = 2; m_pc = 32'h300;
        step("bne_taken",    1, 1, 0, 1, 32'h300, 0, 0, 1, 1, 0);
        step("br_in_redir",  1, 1, 0, 1, 32'h400, 0, 0, 0, 1, 0);
        step("br_in_shadow", 1, 1, 0, 1, 32'h500, 0, 0, 0, 0, 0);
        idle("no_second", 0, 0);

        m_br = 3;
        step("br_not_taken", 1, 1, 0, 0, 32'h480, 0, 0, 0, 0, 0);

        // Both jump and branch flags: treated as a jump, not counted.
        m_pc = 32'h600;
        step("jump_and_br", 1, 1, 1, 0, 32'h600, 0, 0, 1, 1, 0);
        idle("jb_shadow", 0, 1);
        idle("jb_idle",   0, 0);

        m_pc = 32'h100; m_me = 1'b1;
        step("misalign", 1, 0, 1, 0, 32'h102, 0, 0, 1, 1, 0);
        idle("mis_shadow", 0, 1);
        idle("mis_idle",   0, 0);

        for (int i = 0; i < 17; i++) begin
            m_br = sat_inc(m_br);
            m_tk = sat_inc(m_tk);
            m_pc = 32'(32'h1000 + i * 4);
            step("sat_br", 1, 1, 0, 1, m_pc, 0, 0, 1, 1, 0);
            idle("sat_shadow", 0, 1);
            idle("sat_idle",   0, 0);
        end

        // Clear wins over a simultaneous counted, taken branch.
        m_br = 0; m_tk = 0; m_pc = 32'h700;
        step("clr_with_br", 1, 1, 0, 1, 32'h700, 0, 1, 1, 1, 0);
        idle("clr_shadow", 0, 1);
        idle("clr_idle",   0, 0);
        m_br = 1; m_tk = 0;
        step("br_after_clr", 1, 1, 0, 0, 32'h740, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled redirect.
        m_pc = 32'h800;
        step("jal_pre_rst", 1, 0, 1, 0, 32'h800, 1, 0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        m_br = 0; m_tk = 0; m_pc = '0; m_me = 1'b0;
        #1;
        push("async_rst", 1'b0, 1'b0, 1'b0);
        check_out();

        // First edge after release already samples a redirect.
        @(negedge clk);
        rst_n        = 1'b1;
        ex_valid     = 1'b1;
        ex_is_branch = 1'b0;
        ex_is_jump   = 1'b1;
        ex_taken     = 1'b0;
        ex_target    = 32'h900;
        if_stall     = 1'b0;
        clr_counts   = 1'b0;
        m_pc = 32'h900;
        push("first_after_rst", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out();
        idle("post_shadow", 0, 1);
        idle("post_idle",   0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
